// File: rtl/namuru_capture_pkg.sv
// Shared word indices, FSM state type and helpers for namuru_accum_capture.
// NAMURU_CAPTURE_TIMESTAMP_EN adds a timestamp word (word 6) to every channel record.
package namuru_capture_pkg;

  localparam int WORD_IE = 0;
  localparam int WORD_QE = 1;
  localparam int WORD_IP = 2;
  localparam int WORD_QP = 3;
  localparam int WORD_IL = 4;
  localparam int WORD_QL = 5;
  localparam int WORD_TS = 6;

`ifdef NAMURU_CAPTURE_TIMESTAMP_EN
  localparam int NWORDS = 7;
`else
  localparam int NWORDS = 6;
`endif

  localparam logic [2:0] LAST_WORD = 3'(NWORDS - 1);

  // state | meaning
  // IDLE  | pick next pending channel (round robin from rr_ptr)
  // COPY  | write one staged word per cycle into the result RAM
  typedef enum logic {IDLE = 1'b0, COPY = 1'b1} state_t;

  function automatic logic [31:0] sext32(input logic [31:0] v, input int w);
    return $unsigned($signed(v << (32 - w)) >>> (32 - w));
  endfunction

endpackage

// File: rtl/namuru_rr_arbiter.sv
// Round-robin first-set-bit finder: returns the first pending channel at or
// after i_ptr, wrapping modulo NCH.
module namuru_rr_arbiter #(
  parameter int NCH = 12,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] i_pending,
  input  logic [CW-1:0]  i_ptr,
  output logic [CW-1:0]  o_grant,
  output logic           o_any
);

  logic [NCH-1:0] w_rot;

  always_comb begin
    int g;
    g       = 0;
    w_rot   = NCH'({i_pending, i_pending} >> i_ptr);
    o_any   = |i_pending;
    o_grant = '0;
    // Descending scan so the lowest rotated offset wins.
    for (int j = NCH - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        g = int'(i_ptr) + j;
        if (g >= NCH) g = g - NCH;
        o_grant = CW'(g);
      end
    end
  end

endmodule

// File: rtl/namuru_accum_capture.sv
// N-channel correlator dump capture: per-channel staging, round-robin copy into
// a shared result RAM, ready/overrun masks and interrupt. Option: NAMURU_CAPTURE_TIMESTAMP_EN.
module namuru_accum_capture
  import namuru_capture_pkg::*;
#(
  parameter int NCH = 12,
  parameter int W   = 16,
  parameter int AW  = $clog2(NCH) + 3
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [NCH-1:0]     ch_dump,
  input  logic [NCH*6*W-1:0] ch_corr,
  input  logic [23:0]        tic_count,
  input  logic [AW-1:0]      rd_addr,
  output logic [31:0]        rd_data,
  output logic [NCH-1:0]     ready,
  output logic [NCH-1:0]     overrun,
  input  logic               clr_stb,
  input  logic [NCH-1:0]     clr_mask,
  input  logic [NCH-1:0]     int_mask,
  output logic               accum_int,
  output logic               busy
);

  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RD  = NCH * NWORDS;
  localparam int RIW = $clog2(RD);

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_ch, w_ch_nxt, r_rr_ptr, w_rr_nxt, w_grant;
  logic [2:0]     r_word, w_word_nxt;
  logic           w_any, w_wr_en, w_done, w_rd_hit;
  logic [NCH-1:0] r_pending, r_ready, r_overrun;
  logic [NCH-1:0] w_pend_set, w_over_set, w_done_mask, w_clr;
  logic [6*W-1:0] r_stage [NCH];
  logic [W-1:0]   w_words [6];
  logic [31:0]    w_wr_data;
  logic [RIW-1:0] w_wr_idx, w_rd_idx;
  logic [31:0]    r_ram [RD];
  logic [31:0]    r_rd_data;

`ifdef NAMURU_CAPTURE_TIMESTAMP_EN
  logic [23:0] r_stage_ts [NCH];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int c = 0; c < NCH; c++) r_stage_ts[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) if (w_pend_set[c]) r_stage_ts[c] <= tic_count;
    end
  end
`else
  logic w_unused_tic;
  assign w_unused_tic = ^tic_count;
`endif

  namuru_rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
    .i_pending (r_pending),
    .i_ptr     (r_rr_ptr),
    .o_grant   (w_grant),
    .o_any     (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_word_nxt  = r_word;
    w_rr_nxt    = r_rr_ptr;
    w_wr_en     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = COPY;
          w_ch_nxt    = w_grant;
          w_word_nxt  = '0;
        end
      end
      COPY: begin
        w_wr_en    = 1'b1;
        w_word_nxt = r_word + 3'd1;
        if (r_word == LAST_WORD) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
          w_word_nxt  = '0;
          w_rr_nxt    = (int'(r_ch) == NCH - 1) ? '0 : r_ch + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 6; i++) w_words[i] = r_stage[r_ch][i*W +: W];
    w_wr_data = '0;
`ifdef NAMURU_CAPTURE_TIMESTAMP_EN
    if (r_word == 3'(WORD_TS)) w_wr_data = {8'h00, r_stage_ts[r_ch]};
    else                       w_wr_data = sext32(32'(w_words[r_word]), W);
`else
    w_wr_data = sext32(32'(w_words[r_word]), W);
`endif
    w_wr_idx = RIW'(int'(r_ch) * NWORDS + int'(r_word));
  end

  always_comb begin
    int rc, rw;
    rc       = int'(rd_addr >> 3);
    rw       = int'(rd_addr[2:0]);
    w_rd_hit = (rc < NCH) && (rw < NWORDS);
    w_rd_idx = RIW'(rc * NWORDS + rw);
  end

  always_comb begin
    w_clr       = clr_stb ? clr_mask : '0;
    w_pend_set  = ch_dump & ~r_pending;
    // A dump that finds its channel still pending is lost, even mid-copy.
    w_over_set  = ch_dump & r_pending;
    w_done_mask = '0;
    if (w_done) w_done_mask[r_ch] = 1'b1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= IDLE;
      r_ch      <= '0;
      r_word    <= '0;
      r_rr_ptr  <= '0;
      r_pending <= '0;
      r_ready   <= '0;
      r_overrun <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ch      <= w_ch_nxt;
      r_word    <= w_word_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_pending <= (r_pending & ~w_done_mask) | w_pend_set;
      r_ready   <= (r_ready & ~w_clr) | w_done_mask;
      r_overrun <= (r_overrun & ~w_clr) | w_over_set;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int c = 0; c < NCH; c++) r_stage[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) if (w_pend_set[c]) r_stage[c] <= ch_corr[c*6*W +: 6*W];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr_en) r_ram[w_wr_idx] <= w_wr_data;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_rd_data <= '0;
    else         r_rd_data <= w_rd_hit ? r_ram[w_rd_idx] : '0;
  end

  assign rd_data   = r_rd_data;
  assign ready     = r_ready;
  assign overrun   = r_overrun;
  assign accum_int = |(r_ready & int_mask);
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_namuru_accum_capture.sv
// Self-checking bench for namuru_accum_capture: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a channel-level model.
module tb_namuru_accum_capture;

  localparam int NCH = 12;
  localparam int W   = 16;
  localparam int AW  = 7;
`ifdef NAMURU_CAPTURE_TIMESTAMP_EN
  localparam int NW = 7;
  localparam logic [31:0] EXP_W6 = 32'h00ABCDEF;
`else
  localparam int NW = 6;
  localparam logic [31:0] EXP_W6 = 32'h00000000;
`endif

  logic               sys_clk;
  logic               sys_rst;
  logic [NCH-1:0]     ch_dump;
  logic [NCH*6*W-1:0] ch_corr;
  logic [23:0]        tic_count;
  logic [AW-1:0]      rd_addr;
  logic [31:0]        rd_data;
  logic [NCH-1:0]     ready;
  logic [NCH-1:0]     overrun;
  logic               clr_stb;
  logic [NCH-1:0]     clr_mask;
  logic [NCH-1:0]     int_mask;
  logic               accum_int;
  logic               busy;

  namuru_accum_capture #(.NCH(NCH), .W(W), .AW(AW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .ch_dump   (ch_dump),
    .ch_corr   (ch_corr),
    .tic_count (tic_count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .ready     (ready),
    .overrun   (overrun),
    .clr_stb   (clr_stb),
    .clr_mask  (clr_mask),
    .int_mask  (int_mask),
    .accum_int (accum_int),
    .busy      (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Channel-level model: staged samples, a result table, and one copy job at a time.
  logic [15:0]    m_stage [NCH][6];
  logic [23:0]    m_ts    [NCH];
  logic [31:0]    m_ram   [NCH][8];
  bit             m_known [NCH][8];
  logic [NCH-1:0] m_pend, m_ready, m_over;
  bit             m_busy;
  int             m_cur, m_word, m_rr;
  logic [31:0]    m_rd;
  bit             m_rd_known;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int w = 0; w < 8; w++) m_known[c][w] = 0;
      for (int w = 0; w < 6; w++) m_stage[c][w] = '0;
      m_ts[c] = '0;
    end
    m_pend = '0; m_ready = '0; m_over = '0;
    m_busy = 0; m_cur = 0; m_word = 0; m_rr = 0;
    m_rd = '0; m_rd_known = 1;
  endfunction

  function automatic logic [31:0] m_val(input int c, input int w);
    if (w == 6) return {8'h00, m_ts[c]};
    return {{16{m_stage[c][w][15]}}, m_stage[c][w]};
  endfunction

  function automatic void m_step();
    logic [NCH-1:0] old_pend, done, oset, clr;
    int rc, rw;
    old_pend = m_pend; done = '0; oset = '0;
    rc = int'(rd_addr >> 3);
    rw = int'(rd_addr[2:0]);
    if (rc >= NCH || rw >= NW) begin
      m_rd = '0; m_rd_known = 1;
    end else begin
      m_rd = m_ram[rc][rw]; m_rd_known = m_known[rc][rw];
    end
    if (m_busy) begin
      m_ram[m_cur][m_word]   = m_val(m_cur, m_word);
      m_known[m_cur][m_word] = 1;
      m_word++;
      if (m_word == NW) begin
        done[m_cur] = 1'b1;
        m_busy = 0;
        m_rr = (m_cur + 1) % NCH;
      end
    end else if (old_pend != '0) begin
      for (int k = 0; k < NCH; k++) begin
        if (old_pend[(m_rr + k) % NCH]) begin
          m_cur = (m_rr + k) % NCH;
          break;
        end
      end
      m_busy = 1; m_word = 0;
    end
    for (int c = 0; c < NCH; c++) begin
      if (ch_dump[c]) begin
        if (old_pend[c]) oset[c] = 1'b1;
        else begin
          m_pend[c] = 1'b1;
          for (int w = 0; w < 6; w++) m_stage[c][w] = ch_corr[(c*6 + w)*W +: W];
          m_ts[c] = tic_count;
        end
      end
    end
    m_pend  = m_pend & ~done;
    clr     = clr_stb ? clr_mask : '0;
    m_ready = (m_ready & ~clr) | done;
    m_over  = (m_over & ~clr) | oset;
  endfunction

  always @(posedge sys_clk) if (!sys_rst) m_step();

  always @(negedge sys_clk) begin
    if (chk_en && !sys_rst) begin
      check("cyc_ready", 32'(ready), 32'(m_ready));
      check("cyc_overrun", 32'(overrun), 32'(m_over));
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_int", 32'(accum_int), 32'(|(m_ready & int_mask)));
      if (m_rd_known) check("cyc_rd_data", rd_data, m_rd);
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic rand_corr();
    for (int i = 0; i < NCH*6; i++) ch_corr[i*W +: W] = 16'($urandom);
    tic_count = 24'($urandom);
  endtask

  task automatic set_word(input int c, input int w, input logic [15:0] v);
    ch_corr[(c*6 + w)*W +: W] = v;
  endtask

  task automatic clear_all();
    clr_stb = 1'b1; clr_mask = '1;
    tick();
    clr_stb = 1'b0; clr_mask = '0;
  endtask

  task automatic rd_check(input string name, input int c, input int w, input logic [31:0] exp);
    rd_addr = {4'(c), 3'(w)};
    tick();
    check(name, rd_data, exp);
  endtask

  initial begin
    sys_rst = 1'b1; ch_dump = '0; ch_corr = '0; tic_count = '0; rd_addr = '0;
    clr_stb = 1'b0; clr_mask = '0; int_mask = '0;
    m_reset();
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_int", 32'(accum_int), 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    chk_en = 1;

    // Single dump on channel 3.
    rand_corr();
    set_word(3, 0, 16'h8001);
    set_word(3, 5, 16'h0005);
    tic_count = 24'hABCDEF;
    ch_dump = 12'h008;
    tick();
    ch_dump = '0;
    repeat (NW) tick();
    check("t1_ready_early", 32'(ready), 32'h000);
    check("t1_busy", 32'(busy), 32'h1);
    tick();
    check("t1_ready", 32'(ready), 32'h008);
    check("t1_idle", 32'(busy), 32'h0);
    rd_check("t1_word0", 3, 0, 32'hFFFF8001);
    rd_check("t1_word5", 3, 5, 32'h00000005);
    rd_check("t1_word6", 3, 6, EXP_W6);
    rd_check("t1_word7", 3, 7, 32'h0);
    rd_check("t1_bad_ch", 13, 0, 32'h0);
    int_mask = 12'h000; #1 check("t1_int_off", 32'(accum_int), 32'h0);
    int_mask = 12'h008; #1 check("t1_int_on", 32'(accum_int), 32'h1);
    int_mask = 12'hFF7; #1 check("t1_int_other", 32'(accum_int), 32'h0);
    int_mask = '0;

    // Simultaneous dumps with rr_ptr = 6.
    clear_all();
    ch_dump = 12'h020; tick(); ch_dump = '0;
    repeat (NW + 1) tick();
    check("t2_pre_ready", 32'(ready), 32'h020);
    clear_all();
    rand_corr();
    ch_dump = 12'h821; tick(); ch_dump = '0;
    repeat (NW) tick();
    check("t2_none_yet", 32'(ready), 32'h000);
    tick();
    check("t2_first_11", 32'(ready), 32'h800);
    repeat (NW + 1) tick();
    check("t2_second_0", 32'(ready), 32'h801);
    repeat (NW + 1) tick();
    check("t2_third_5", 32'(ready), 32'h821);
    clear_all();
    ch_dump = 12'h081; tick(); ch_dump = '0;
    repeat (NW + 1) tick();
    check("t2_rr_is_6", 32'(ready), 32'h080);
    repeat (NW + 1) tick();
    check("t2_rr_then_0", 32'(ready), 32'h081);

    // Overrun: second dump on channel 2 three cycles later is dropped.
    clear_all();
    rand_corr();
    set_word(2, 0, 16'h1234);
    ch_dump = 12'h004; tick(); ch_dump = '0;
    tick(); tick();
    set_word(2, 0, 16'hBEEF);
    ch_dump = 12'h004; tick(); ch_dump = '0;
    check("t3_overrun", 32'(overrun), 32'h004);
    repeat (NW - 3) tick();
    check("t3_ready_early", 32'(ready), 32'h000);
    tick();
    check("t3_ready", 32'(ready), 32'h004);
    rd_check("t3_first_sample", 2, 0, 32'h00001234);

    // Set beats clear on the same edge.
    clear_all();
    int_mask = 12'h010;
    ch_dump = 12'h010; tick(); ch_dump = '0;
    repeat (NW) tick();
    clr_stb = 1'b1; clr_mask = 12'h010;
    tick();
    check("t4_set_wins", 32'(ready), 32'h010);
    check("t4_int_high", 32'(accum_int), 32'h1);
    tick();
    check("t4_cleared", 32'(ready), 32'h000);
    check("t4_int_low", 32'(accum_int), 32'h0);
    clr_stb = 1'b0; clr_mask = '0;

    // Asynchronous reset during COPY word 3.
    int_mask = '1;
    rand_corr();
    set_word(8, 0, 16'h7ABC);
    ch_dump = 12'h100; tick(); ch_dump = '0;
    repeat (NW + 1) tick();
    check("t5_pre_ready", 32'(ready), 32'h100);
    rd_addr = {4'd8, 3'd0};
    ch_dump = 12'h002; tick();
    tick();
    ch_dump = '0;
    tick(); tick(); tick();
    check("t5_busy_mid", 32'(busy), 32'h1);
    check("t5_overrun_mid", 32'(overrun), 32'h002);
    check("t5_rd_mid", rd_data, 32'h00007ABC);
    #2 sys_rst = 1'b1;
    m_reset();
    #1;
    check("t5_rst_ready", 32'(ready), 32'h0);
    check("t5_rst_overrun", 32'(overrun), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_int", 32'(accum_int), 32'h0);
    check("t5_rst_rd", rd_data, 32'h0);
    repeat (2) tick();
    sys_rst = 1'b0;
    rand_corr();
    set_word(6, 1, 16'hC003);
    ch_dump = 12'h040; tick(); ch_dump = '0;
    repeat (NW + 1) tick();
    check("t5_after_ready", 32'(ready), 32'h040);
    rd_check("t5_after_word1", 6, 1, 32'hFFFFC003);

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      rand_corr();
      ch_dump = ($urandom_range(0, 7) == 0) ? (NCH'($urandom) & NCH'($urandom)) : '0;
      rd_addr = AW'($urandom);
      clr_stb = ($urandom_range(0, 7) == 0);
      clr_mask = NCH'($urandom);
      if ($urandom_range(0, 15) == 0) int_mask = NCH'($urandom);
      tick();
    end
    ch_dump = '0; clr_stb = 1'b0;
    repeat (NCH * (NW + 1) + 4) tick();
    for (int a = 0; a < 128; a++) begin
      rd_addr = AW'(a);
      tick();
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
